iob_plic_claim_ctrl: RTL and testbench

IOB_PLIC_CLAIM_CTRL -- requirements
Module: iob_plic_claim_ctrl

---
 rtl/iob_plic_claim_ctrl.sv | 168 ++++++++++++++++
 tb/tb_iob_plic_claim_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_plic_claim_ctrl.sv
// Purpose : PLIC claim/complete sequencer. On a target interrupt it reads the
//           claim register over IOb, hands the ID to a handler, then writes the
//           ID back to the same register to complete it.
// Latency : irq_i -> iob_avalid_o 1 cycle; irq_i -> id_valid_o 3 cycles with
//           ready=1 and rvalid one cycle after the read is accepted.
// Backpressure: iob_avalid_o, address, data and strobes are held until
//           iob_ready_i=1. A stalled handler is cut off by the timeout counter.
//
// Ports:
//   clk_i, arst_n_i            clock, asynchronous active-low reset
//   cke_i                      clock enable; all state freezes when low
//   enable_i, irq_i            start qualifier and PLIC target interrupt
//   iob_avalid_o .. iob_ready_i IOb master port (wstrb==0 means read)
//   id_o, id_valid_o, done_i   handler hand-off
//   busy_o                     sequencer not idle
//   timeout_o                  sticky: a handler overran its cycle budget
//   spurious_cnt_o             saturating count of claims that returned ID 0

module iob_plic_claim_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] CLAIM_ADDR = 16'h0400,
    parameter int                ID_W       = 4,
    parameter int                TIMEOUT_W  = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                enable_i,
    input  logic                irq_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i,
    output logic [ID_W-1:0]     id_o,
    output logic                id_valid_o,
    input  logic                done_i,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [7:0]          spurious_cnt_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_REQ   = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_DISPATCH = 3'd3;
    localparam logic [2:0] ST_WR_REQ   = 3'd4;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]           SPUR_MAX = 8'hFF;

    logic [2:0]           state_q,   state_d;
    logic [ID_W-1:0]      id_q,      id_d;
    logic [TIMEOUT_W-1:0] cnt_q,     cnt_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           spur_q,    spur_d;

    logic [ID_W-1:0]      rd_id;
    logic [DATA_W-1:0]    wdata_ext;

    // Only the low ID_W bits of the claim register carry the ID; the rest of
    // the read word is deliberately dropped.
    logic unused_rdata;
    assign unused_rdata = ^iob_rdata_i;
    assign rd_id        = iob_rdata_i[ID_W-1:0];

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        spur_d    = spur_q;
        if (cke_i) begin
            case (state_q)
                ST_IDLE: begin
                    // irq_i is only looked at here; leaving WR_REQ always
                    // passes through one IDLE cycle before a new read.
                    if (enable_i && irq_i) begin
                        state_d = ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (iob_ready_i) begin
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (iob_rvalid_i) begin
                        if (rd_id == '0) begin
                            // Nothing pending at the PLIC: count it, no
                            // completion write is owed.
                            if (spur_q != SPUR_MAX) begin
                                spur_d = spur_q + 8'd1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            id_d    = rd_id;
                            cnt_d   = '0;
                            state_d = ST_DISPATCH;
                        end
                    end
                end
                ST_DISPATCH: begin
                    // done_i takes priority over the timeout in the same cycle.
                    if (done_i) begin
                        state_d = ST_WR_REQ;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WR_REQ: begin
                    // A write is complete on acceptance; no rvalid expected.
                    if (iob_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            spur_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            spur_q    <= spur_d;
        end
    end

    // Bus outputs decode straight from the state register so that reset
    // removes a pending request immediately, and request fields cannot
    // change while a request waits for ready.
    always_comb begin
        wdata_ext = '0;
        if (state_q == ST_WR_REQ) begin
            wdata_ext[ID_W-1:0] = id_q;
        end
    end

    assign iob_avalid_o   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign iob_addr_o     = iob_avalid_o ? CLAIM_ADDR : '0;
    assign iob_wdata_o    = wdata_ext;
    assign iob_wstrb_o    = (state_q == ST_WR_REQ) ? '1 : '0;

    assign id_o           = id_q;
    assign id_valid_o     = (state_q == ST_DISPATCH);
    assign busy_o         = (state_q != ST_IDLE);
    assign timeout_o      = timeout_q;
    assign spurious_cnt_o = spur_q;

endmodule

// File: tb/tb_iob_plic_claim_ctrl.sv
// Purpose : self-checking bench for iob_plic_claim_ctrl (TIMEOUT_W=4).
// Latency : n/a (bench).
// Backpressure: the bench plays IOb slave and handler, with random stalls.

module tb_iob_plic_claim_ctrl;

    localparam int          TW     = 4;
    localparam logic [15:0] CLAIM  = 16'h0400;

    logic        clk = 1'b0;
    logic        arst_n_i;
    logic        cke_i, enable_i, irq_i;
    logic        iob_avalid_o;
    logic [15:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;
    logic        iob_ready_i;
    logic [3:0]  id_o;
    logic        id_valid_o;
    logic        done_i;
    logic        busy_o, timeout_o;
    logic [7:0]  spurious_cnt_o;

    iob_plic_claim_ctrl #(
        .ADDR_W(16), .DATA_W(32), .CLAIM_ADDR(CLAIM), .ID_W(4), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i), .enable_i(enable_i),
        .irq_i(irq_i), .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
        .iob_ready_i(iob_ready_i), .id_o(id_o), .id_valid_o(id_valid_o),
        .done_i(done_i), .busy_o(busy_o), .timeout_o(timeout_o),
        .spurious_cnt_o(spurious_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_reads = 0;
    int n_writes = 0;
    int n_disp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: where the claim sequence stands, in the terms a
    // software person would use, plus the observable counters.
    typedef enum int {P_IDLE, P_READ, P_RWAIT, P_HANDLER, P_WRITE} phase_t;
    phase_t      m_phase;
    logic [3:0]  m_id;
    int          m_hcyc;     // handler cycles already spent
    logic        m_timeout;
    int          m_spur;

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_id      = 4'd0;
        m_hcyc    = 0;
        m_timeout = 1'b0;
        m_spur    = 0;
    endtask

    task automatic model_advance(input logic irq, input logic en, input logic rdy,
                                 input logic rv, input logic [31:0] rd,
                                 input logic dn, input logic ck);
        if (!ck) return;
        case (m_phase)
            P_IDLE:  if (en && irq) m_phase = P_READ;
            P_READ:  if (rdy) m_phase = P_RWAIT;
            P_RWAIT: if (rv) begin
                if (rd[3:0] == 4'd0) begin
                    m_spur  = (m_spur >= 255) ? 255 : m_spur + 1;
                    m_phase = P_IDLE;
                end else begin
                    m_id    = rd[3:0];
                    m_hcyc  = 0;
                    m_phase = P_HANDLER;
                end
            end
            P_HANDLER: begin
                m_hcyc = m_hcyc + 1;
                if (dn) begin
                    m_phase = P_WRITE;
                end else if (m_hcyc == (1 << TW)) begin
                    m_timeout = 1'b1;
                    m_phase   = P_WRITE;
                end
            end
            P_WRITE: if (rdy) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        logic exp_av;
        logic is_wr;
        exp_av = (m_phase == P_READ) || (m_phase == P_WRITE);
        is_wr  = (m_phase == P_WRITE);
        check("avalid", 32'(iob_avalid_o), 32'(exp_av));
        if (exp_av) begin
            check("addr",  32'(iob_addr_o),  32'(CLAIM));
            check("wstrb", 32'(iob_wstrb_o), is_wr ? 32'hF : 32'h0);
            check("wdata", iob_wdata_o,      is_wr ? 32'(m_id) : 32'h0);
        end else begin
            check("wdata_idle", iob_wdata_o,      32'h0);
            check("wstrb_idle", 32'(iob_wstrb_o), 32'h0);
        end
        check("id_valid", 32'(id_valid_o), 32'(m_phase == P_HANDLER));
        if (m_phase == P_HANDLER) check("id", 32'(id_o), 32'(m_id));
        check("busy",    32'(busy_o),         32'(m_phase != P_IDLE));
        check("timeout", 32'(timeout_o),      32'(m_timeout));
        check("spur",    32'(spurious_cnt_o), 32'(m_spur));
    endtask

    // One clock: check outputs (we sit just after a falling edge), drive the
    // inputs for the next rising edge, then advance the model across it.
    task automatic step(input logic irq, input logic en, input logic rdy,
                        input logic rv, input logic [31:0] rd,
                        input logic dn, input logic ck);
        compare_outputs();
        irq_i = irq; enable_i = en; iob_ready_i = rdy; iob_rvalid_i = rv;
        iob_rdata_i = rd; done_i = dn; cke_i = ck;
        if (ck && iob_avalid_o && rdy) begin
            if (iob_wstrb_o == 4'd0) n_reads++;
            else                     n_writes++;
        end
        if (id_valid_o) n_disp++;
        @(posedge clk);
        model_advance(irq, en, rdy, rv, rd, dn, ck);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic irq, input logic en);
        for (int i = 0; i < n; i++) step(irq, en, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Read the claim register and get 'id' back one cycle after acceptance.
    task automatic claim(input logic [31:0] id);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, id,    1'b0, 1'b1);
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        #1;
        check("rst_avalid",  32'(iob_avalid_o),   32'h0);
        check("rst_addr",    32'(iob_addr_o),     32'h0);
        check("rst_wdata",   iob_wdata_o,         32'h0);
        check("rst_wstrb",   32'(iob_wstrb_o),    32'h0);
        check("rst_id",      32'(id_o),           32'h0);
        check("rst_idvalid", 32'(id_valid_o),     32'h0);
        check("rst_busy",    32'(busy_o),         32'h0);
        check("rst_timeout", 32'(timeout_o),      32'h0);
        check("rst_spur",    32'(spurious_cnt_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        arst_n_i = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, d0;
        logic [31:0] rd;
        arst_n_i = 1'b1; cke_i = 1'b1; enable_i = 1'b1; irq_i = 1'b1;
        iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0; iob_ready_i = 1'b0; done_i = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();   // irq/enable held high through reset: first start needs a fresh sample

        // Basic service and latency.
        idle(2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("lat_avalid", 32'(iob_avalid_o), 32'h1);
        check("basic_rd_addr", 32'(iob_addr_o), 32'h400);
        check("basic_rd_wstrb", 32'(iob_wstrb_o), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 1'b0, 1'b1);
        check("lat_idvalid", 32'(id_valid_o), 32'h1);
        check("basic_id", 32'(id_o), 32'h5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("basic_wdata", iob_wdata_o, 32'h5);
        check("basic_wstrb", 32'(iob_wstrb_o), 32'hF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("basic_idle", 32'(busy_o), 32'h0);

        // Spurious claims.
        do_reset();
        w0 = n_writes; d0 = n_disp;
        for (int i = 0; i < 3; i++) begin
            claim(32'hABCD_0000);
        end
        idle(2, 1'b0, 1'b1);
        check("spur_cnt", 32'(spurious_cnt_o), 32'd3);
        check("spur_nowrite", 32'(n_writes - w0), 32'd0);
        check("spur_nodisp", 32'(n_disp - d0), 32'd0);

        // Backpressure in both request phases.
        r0 = n_reads; w0 = n_writes;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h9, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        check("bp_reads", 32'(n_reads - r0), 32'd1);
        check("bp_writes", 32'(n_writes - w0), 32'd1);

        // Timeout: 16 handler cycles (counter 0..15) without done.
        do_reset();
        claim(32'h3);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("to_not_yet", 32'(timeout_o), 32'h0);
        check("to_still_disp", 32'(id_valid_o), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("to_set", 32'(timeout_o), 32'h1);
        check("to_wdata", iob_wdata_o, 32'h3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // done_i on the last counted cycle wins over the timeout.
        do_reset();
        claim(32'h6);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("to_done_wins", 32'(timeout_o), 32'h0);
        check("to_done_wstrb", 32'(iob_wstrb_o), 32'hF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Clock enable low freezes everything, even with ready/done offered.
        claim(32'h7);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        check("cke_hold", 32'(id_valid_o), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("cke_hold_wr", 32'(iob_avalid_o), 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // enable_i dropped mid-sequence: finish, then stay idle.
        r0 = n_reads;
        claim(32'hA);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(10, 1'b1, 1'b0);
        check("en_drop_reads", 32'(n_reads - r0), 32'd1);
        check("en_drop_idle", 32'(busy_o), 32'h0);

        // Reset in the middle of a stalled write.
        claim(32'hC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("wr_pending", 32'(iob_avalid_o), 32'h1);
        do_reset();

        // Spurious counter saturation.
        for (int i = 0; i < 260; i++) claim(32'h0);
        check("spur_sat", 32'(spurious_cnt_o), 32'd255);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd = $urandom;
            if ($urandom_range(3) == 0) rd[3:0] = 4'd0;
            step($urandom_range(3) != 0, $urandom_range(7) != 0,
                 $urandom_range(2) != 0, $urandom_range(2) == 0, rd,
                 $urandom_range(9) == 0, $urandom_range(9) != 0);
        end
        compare_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
